// File: rtl/rtc_pkg.sv
// rtc_pkg: button indices and default 50 MHz timing shared by the button front end.
package rtc_pkg;
    localparam int NUM_BTN = 5;
    localparam int BTN_P = 0;
    localparam int BTN_R = 1;
    localparam int BTN_L = 2;
    localparam int BTN_U = 3;
    localparam int BTN_D = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 250_000;
    localparam int DEF_REPEAT_DELAY = 25_000_000;
    localparam int DEF_REPEAT_PERIOD = 5_000_000;
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: two-flop synchroniser, debounce counter and rising-edge detect for one button.
module debounce_cell
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    logic flip;
    // the Nth consecutive disagreeing edge flips the level instead of counting to N
    assign flip = (s2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            cnt <= '0;
            level <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            cnt <= (s2 == level || flip) ? '0 : cnt + 1'b1;
            level <= flip ? ~level : level;
            rise <= flip && !level;
        end
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced, prioritised single-cycle button pulses with up/down auto-repeat.
module button_conditioner
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
    parameter bit AUTOREPEAT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btnp_raw,
    input  logic btnr_raw,
    input  logic btnl_raw,
    input  logic btnu_raw,
    input  logic btnd_raw,
    output logic btnp,
    output logic btnr,
    output logic btnl,
    output logic btnu,
    output logic btnd,
    output logic [NUM_BTN-1:0] btn_level
);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    logic [NUM_BTN-1:0] raw, level, rise, rep, cand, sel;
    assign raw = {btnd_raw, btnu_raw, btnl_raw, btnr_raw, btnp_raw};
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_cell
        debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cell (
            .clk(clk),
            .reset(reset),
            .raw(raw[i]),
            .level(level[i]),
            .rise(rise[i])
        );
    end
    // count down to 1, fire, reload; 0 means idle
    for (genvar i = BTN_U; i <= BTN_D; i++) begin : g_rep
        logic [RW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (reset || !level[i])
                cnt <= '0;
            else if (rise[i])
                cnt <= RW'(REPEAT_DELAY);
            else if (cnt == RW'(1))
                cnt <= RW'(REPEAT_PERIOD);
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
        assign rep[i] = AUTOREPEAT && level[i] && (cnt == RW'(1));
    end
    assign rep[BTN_L:BTN_P] = '0;
    assign cand = rise | rep;
    always_comb begin
        sel = '0;
        sel[BTN_P] = cand[BTN_P];
        sel[BTN_R] = cand[BTN_R] && !cand[BTN_P];
        sel[BTN_L] = cand[BTN_L] && !cand[BTN_P] && !cand[BTN_R];
        sel[BTN_U] = cand[BTN_U] && !cand[BTN_P];
        sel[BTN_D] = cand[BTN_D] && !cand[BTN_P] && !cand[BTN_U];
    end
    always_ff @(posedge clk) begin
        if (reset)
            {btnd, btnu, btnl, btnr, btnp} <= '0;
        else
            {btnd, btnu, btnl, btnr, btnp} <= sel;
    end
    assign btn_level = level;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus checked against a window/arithmetic reference model.
module tb_button_conditioner;
    import rtc_pkg::*;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btnp_raw = 1'b0, btnr_raw = 1'b0, btnl_raw = 1'b0, btnu_raw = 1'b0, btnd_raw = 1'b0;
    logic btnp, btnr, btnl, btnu, btnd;
    logic [4:0] btn_level;
    logic [4:0] obs;
    int compared = 0;
    int failed = 0;
    always #5 clk = ~clk;
    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .AUTOREPEAT(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btnp_raw(btnp_raw),
        .btnr_raw(btnr_raw),
        .btnl_raw(btnl_raw),
        .btnu_raw(btnu_raw),
        .btnd_raw(btnd_raw),
        .btnp(btnp),
        .btnr(btnr),
        .btnl(btnl),
        .btnu(btnu),
        .btnd(btnd),
        .btn_level(btn_level)
    );
    assign obs = {btnd, btnu, btnl, btnr, btnp};
    // reference model: stable level flips once the last DB synchronised samples all disagree;
    // repeats are arithmetic offsets from the press edge
    int n = 0;
    logic [4:0] m_s1 = '0, m_s2 = '0, stab = '0, rose = '0, exp_out = '0, exp_lvl = '0;
    int press[5] = '{default: -1};
    logic [4:0] win[$];
    function automatic logic [4:0] arbitrate(input logic [4:0] c);
        logic [4:0] o;
        o = '0;
        if (c[BTN_P]) o[BTN_P] = 1'b1;
        else if (c[BTN_R]) o[BTN_R] = 1'b1;
        else if (c[BTN_L]) o[BTN_L] = 1'b1;
        if (!c[BTN_P]) begin
            if (c[BTN_U]) o[BTN_U] = 1'b1;
            else if (c[BTN_D]) o[BTN_D] = 1'b1;
        end
        return o;
    endfunction
    task automatic step(input logic [4:0] v, input logic r);
        logic [4:0] cand, s2u;
        logic diff;
        {btnd_raw, btnu_raw, btnl_raw, btnr_raw, btnp_raw} = v;
        reset = r;
        @(posedge clk);
        #1;
        n++;
        cand = '0;
        if (!r) begin
            cand = rose;
            for (int b = BTN_U; b <= BTN_D; b++)
                if (stab[b] && press[b] >= 0 && (n - 1 - press[b]) >= RD && ((n - 1 - press[b] - RD) % RP) == 0)
                    cand[b] = 1'b1;
        end
        exp_out = arbitrate(cand);
        s2u = m_s2;
        m_s2 = r ? '0 : m_s1;
        m_s1 = r ? '0 : v;
        rose = '0;
        if (r) begin
            win.delete();
            stab = '0;
            foreach (press[b]) press[b] = -1;
        end else begin
            win.push_back(s2u);
            if (win.size() > DB) void'(win.pop_front());
            for (int b = 0; b < 5; b++) begin
                if (win.size() == DB) begin
                    diff = 1'b1;
                    foreach (win[j]) if (win[j][b] == stab[b]) diff = 1'b0;
                    if (diff) begin
                        stab[b] = ~stab[b];
                        if (stab[b]) begin
                            rose[b] = 1'b1;
                            press[b] = n;
                        end
                    end
                end
            end
        end
        exp_lvl = stab;
    endtask
    task automatic idle(input int c);
        for (int i = 0; i < c; i++) step('0, 1'b0);
    endtask
    task automatic test_reset;
        for (int k = 1; k <= 3; k++) begin
            step(5'($urandom), 1'b1);
            compared++;
            if (obs !== 5'b0 || btn_level !== 5'b0) begin
                failed++;
                $display("FAIL reset step %0d: pulses=%b level=%b, want 00000/00000", k, obs, btn_level);
            end
        end
        idle(10);
    endtask
    task automatic test_clean_press;
        int first, cnt, lvl_first;
        first = -1; cnt = 0; lvl_first = -1;
        for (int k = 1; k <= 30; k++) begin
            step(k <= 20 ? 5'b00010 : 5'b00000, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL clean_press step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (btnr) begin cnt++; if (first < 0) first = k; end
            if (btn_level[BTN_R] && lvl_first < 0) lvl_first = k;
        end
        compared++;
        if (first != DB + 3 || cnt != 1) begin
            failed++;
            $display("FAIL clean_press_pulse: first=%0d count=%0d, want first=%0d count=1", first, cnt, DB + 3);
        end
        compared++;
        if (lvl_first != DB + 2) begin
            failed++;
            $display("FAIL clean_press_level: level rose at %0d, want %0d", lvl_first, DB + 2);
        end
        idle(12);
    endtask
    task automatic test_bounce;
        logic [4:0] pat;
        int first, cnt;
        pat = 5'b01101;
        first = -1; cnt = 0;
        for (int k = 1; k <= 37; k++) begin
            step((k <= 5 ? pat[k-1] : k <= 25) ? 5'b00100 : 5'b00000, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL bounce step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (btnl) begin cnt++; if (first < 0) first = k; end
        end
        compared++;
        if (first != 6 + DB + 2 || cnt != 1) begin
            failed++;
            $display("FAIL bounce_pulse: first=%0d count=%0d, want first=%0d count=1", first, cnt, 6 + DB + 2);
        end
        idle(12);
    endtask
    task automatic test_autorepeat;
        int cnt, first, second, last;
        cnt = 0; first = -1; second = -1; last = -1;
        for (int k = 1; k <= 50; k++) begin
            step(k <= 40 ? 5'b01000 : 5'b00000, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL autorepeat step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (btnu) begin
                cnt++;
                if (first < 0) first = k; else if (second < 0) second = k;
                last = k;
            end
        end
        // level holds through edge 45, so repeats land on 17,20,...,44
        compared++;
        if (cnt != 11 || first != 7 || second != 17 || last != 44) begin
            failed++;
            $display("FAIL autorepeat_u: count=%0d first=%0d second=%0d last=%0d, want 11 7 17 44", cnt, first, second, last);
        end
        idle(12);
        cnt = 0;
        for (int k = 1; k <= 50; k++) begin
            step(k <= 40 ? 5'b00001 : 5'b00000, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL no_repeat_p step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (btnp) cnt++;
        end
        compared++;
        if (cnt != 1) begin
            failed++;
            $display("FAIL no_repeat_p_count: count=%0d, want 1", cnt);
        end
        idle(12);
    endtask
    task automatic test_priority;
        int dcnt, ufirst;
        for (int k = 1; k <= 20; k++) begin
            step(5'b01011, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL priority_pru step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (k == DB + 3) begin
                compared++;
                if (obs !== 5'b00001) begin
                    failed++;
                    $display("FAIL priority_p_wins: pulses=%b, want 00001", obs);
                end
            end
        end
        idle(12);
        dcnt = 0; ufirst = -1;
        for (int k = 1; k <= 25; k++) begin
            step(5'b11000, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL priority_ud step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (btnd) dcnt++;
            if (btnu && ufirst < 0) ufirst = k;
        end
        compared++;
        if (dcnt != 0 || ufirst != DB + 3) begin
            failed++;
            $display("FAIL priority_u_wins: d_pulses=%0d u_first=%0d, want 0 and %0d", dcnt, ufirst, DB + 3);
        end
        idle(12);
    endtask
    task automatic test_reset_mid;
        int stale, got7, got18;
        logic r;
        stale = 0; got7 = 0; got18 = 0;
        for (int k = 1; k <= 30; k++) begin
            r = (k >= 9 && k <= 11);
            step(5'b10000, r);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL reset_mid step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (r) begin
                compared++;
                if (obs !== 5'b0 || btn_level !== 5'b0) begin
                    failed++;
                    $display("FAIL reset_mid_zero step %0d: pulses=%b level=%b, want zeros", k, obs, btn_level);
                end
            end
            if (btnd && k == 7) got7 = 1;
            if (btnd && k == 18) got18 = 1;
            if (btnd && k > 7 && k < 18) stale++;
        end
        compared++;
        if (got7 != 1 || got18 != 1 || stale != 0) begin
            failed++;
            $display("FAIL reset_mid_pulses: at7=%0d at18=%0d stale=%0d, want 1 1 0", got7, got18, stale);
        end
        idle(12);
    endtask
    task automatic test_glitch;
        int cnt, lv;
        cnt = 0; lv = 0;
        for (int k = 1; k <= 18; k++) begin
            step(k <= 3 ? 5'b00001 : 5'b00000, 1'b0);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL glitch step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
            if (btnp) cnt++;
            if (btn_level[BTN_P]) lv++;
        end
        compared++;
        if (cnt != 0 || lv != 0) begin
            failed++;
            $display("FAIL glitch_reject: pulses=%0d level_high_cycles=%0d, want 0 0", cnt, lv);
        end
    endtask
    task automatic test_random;
        logic [4:0] v;
        int hold;
        logic r;
        hold = 0;
        v = '0;
        for (int k = 1; k <= 600; k++) begin
            if (hold == 0) begin
                v = 5'($urandom);
                hold = $urandom_range(1, 18);
            end
            hold--;
            r = ($urandom_range(0, 59) == 0);
            step(v, r);
            compared++;
            if (obs !== exp_out || btn_level !== exp_lvl) begin
                failed++;
                $display("FAIL random step %0d: pulses=%b level=%b, want %b %b", k, obs, btn_level, exp_out, exp_lvl);
            end
        end
    endtask
    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_autorepeat;
        test_priority;
        test_reset_mid;
        test_glitch;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
